// File: rtl/rdma_rx_pkg.sv
// Shared definitions for the RDMA RX arbiter: FSM state encoding and default beat width.
package rdma_rx_pkg;

    localparam int RDMA_DATA_W = 64;

    // IDLE arbitrates, BUSY forwards the granted packet, FLUSH discards the
    // rest of a packet the watchdog has already terminated.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/rdma_rx_rr_pick.sv
// Combinational round-robin picker: the first eligible requester strictly after
// i_last_grant, wrapping around, so the previous winner has the lowest priority.
module rdma_rx_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_elig,
    input  logic [$clog2(N_REQ)-1:0] i_last_grant,
    output logic [$clog2(N_REQ)-1:0] o_winner,
    output logic                     o_any
);

    localparam int IDX_W = $clog2(N_REQ);

    // Walk from the farthest offset down to the nearest so the nearest eligible
    // requester after the last grant is the final assignment.
    always_comb begin
        o_winner = '0;
        o_any    = |i_elig;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_elig[(int'(i_last_grant) + k) % N_REQ]) begin
                o_winner = IDX_W'((int'(i_last_grant) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rdma_rx_arb.sv
// Packet-level round-robin arbiter sharing one RDMA RX datapath between N_REQ
// receive streams. A grant is held until the owner's last beat; beats leave
// through a registered output stage.
// Optional stall watchdog: define RDMA_RX_ARB_WDOG_EN.
module rdma_rx_arb
    import rdma_rx_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = RDMA_DATA_W,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_mask,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [$clog2(N_REQ)-1:0]  out_src,
    output logic                      out_err
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_grant_next;
    logic [N_REQ-1:0]   w_elig;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic               w_xfer;
    logic               w_beat_last;
    logic               w_wdog_fire;
    logic               r_out_valid;
    logic               r_out_last;
    logic [DATA_W-1:0]  r_out_data;
    logic [IDX_W-1:0]   r_out_src;

    // Masking gates only new grants; the owner of a packet in flight keeps it.
    assign w_elig = req_valid & req_mask;

    rdma_rx_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    // Ready is one-hot on the owner in BUSY and FLUSH, zero while arbitrating.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (r_state != ST_IDLE) && (r_grant == IDX_W'(gi));
        end
    endgenerate

    assign w_xfer      = (r_state != ST_IDLE) && req_valid[r_grant];
    assign w_beat_last = req_last[r_grant];

`ifdef RDMA_RX_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] r_wdog_cnt;
    logic             r_out_err;

    // Fires during the stall cycle that brings the count to WDOG_CYCLES, so the
    // error beat appears on the following cycle.
    assign w_wdog_fire = (r_state == ST_BUSY) && !req_valid[r_grant] &&
                         (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

    // Count consecutive stalled BUSY cycles; any transfer or other state clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= '0;
        end else if ((r_state == ST_BUSY) && !req_valid[r_grant] && !w_wdog_fire) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end else begin
            r_wdog_cnt <= '0;
        end
    end

    // Error flag rides with the synthetic terminating beat only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_err <= 1'b0;
        end else begin
            r_out_err <= w_wdog_fire;
        end
    end

    assign out_err = r_out_err;
`else
    assign w_wdog_fire = 1'b0;
    assign out_err     = 1'b0;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next state: arbitrate in IDLE, release on the owner's last beat.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next      = ST_BUSY;
                    w_grant_next      = w_winner;
                    w_last_grant_next = w_winner;
                end
            end
            ST_BUSY: begin
                if (w_xfer && w_beat_last) begin
                    w_state_next = ST_IDLE;
                end else if (w_wdog_fire) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_xfer && w_beat_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output stage: one-cycle latency; data/src hold when no beat is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if ((r_state == ST_BUSY) && w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_beat_last;
                r_out_data  <= req_data[int'(r_grant)*DATA_W +: DATA_W];
                r_out_src   <= r_grant;
            end else if (w_wdog_fire) begin
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b1;
                r_out_data  <= '0;
                r_out_src   <= r_grant;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
